// File: rtl/load_timer_pkg.sv
// Shared types and defaults for the loadable counter/timer exercise set.
package load_timer_pkg;

    // Timer FSM states; IDLE must stay at the all-zero encoding so reset lands there.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } timer_state_t;

    localparam int TIMER_WIDTH_DEFAULT = 4;

endpackage : load_timer_pkg

// File: rtl/load_down_timer.sv
// Loadable down-counting timer with one-cycle expiry pulse, pause/abort
// control and optional auto-reload for periodic tick generation.
module load_down_timer
    import load_timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             auto_reload_i,
    input  logic             pause_i,
    input  logic             abort_i,
    output logic             load_ready_o,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             expire_o
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    timer_state_t     state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_val_q;
    logic             reload_flag_q;
    logic             busy_q;
    logic             expire_q;
    logic             load_accept;

    // Loads are only taken in IDLE, and never while reset is asserted.
    assign load_ready_o = (state_q == IDLE) && !reset;
    assign load_accept  = load_valid_i && load_ready_o;

    assign count_o  = count_q;
    assign busy_o   = busy_q;
    assign expire_o = expire_q;

    // Timer FSM: reset > abort > pause > decrement/expiry; busy and expire are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            count_q       <= ZERO;
            reload_val_q  <= ZERO;
            reload_flag_q <= 1'b0;
            busy_q        <= 1'b0;
            expire_q      <= 1'b0;
        end else begin
            expire_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_accept) begin
                        if (load_val_i != ZERO) begin
                            count_q       <= load_val_i;
                            reload_val_q  <= load_val_i;
                            reload_flag_q <= auto_reload_i;
                            busy_q        <= 1'b1;
                            state_q       <= RUN;
                        end else begin
                            // Zero-length timer: expire immediately without ever going busy.
                            count_q  <= ZERO;
                            expire_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        count_q <= ZERO;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (pause_i) begin
                        state_q <= HOLD;
                    end else if (count_q > ONE) begin
                        count_q <= count_q - ONE;
                    end else begin
                        // Final tick: either restart the period or drop back to IDLE.
                        expire_q <= 1'b1;
                        if (reload_flag_q) begin
                            count_q <= reload_val_q;
                        end else begin
                            count_q <= ZERO;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (abort_i) begin
                        count_q <= ZERO;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (!pause_i) begin
                        // Resume without decrementing on this edge.
                        state_q <= RUN;
                    end
                end
                default: begin
                    count_q <= ZERO;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule : load_down_timer

// File: tb/tb_load_down_timer.sv
// Self-checking bench for load_down_timer: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_load_down_timer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load_valid_i = 1'b0;
    logic [W-1:0] load_val_i = '0;
    logic         auto_reload_i = 1'b0;
    logic         pause_i = 1'b0;
    logic         abort_i = 1'b0;
    logic         load_ready_o;
    logic [W-1:0] count_o;
    logic         busy_o;
    logic         expire_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: remaining ticks, programmed period, modes.
    bit m_active = 0;
    bit m_paused = 0;
    bit m_periodic = 0;
    bit m_expire = 0;
    int m_rem = 0;
    int m_period = 0;
    bit model_on = 0;

    load_down_timer #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid_i (load_valid_i),
        .load_val_i   (load_val_i),
        .auto_reload_i(auto_reload_i),
        .pause_i      (pause_i),
        .abort_i      (abort_i),
        .load_ready_o (load_ready_o),
        .count_o      (count_o),
        .busy_o       (busy_o),
        .expire_o     (expire_o)
    );

    // 10 time-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs; returns at the following negedge, after the edge took effect.
    task automatic applyStimulus(input bit rst, input bit lv, input int val,
                                 input bit ar, input bit pa, input bit ab);
        reset         = rst;
        load_valid_i  = lv;
        load_val_i    = W'(val);
        auto_reload_i = ar;
        pause_i       = pa;
        abort_i       = ab;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    // Model of the timer's rules, advanced once per rising edge from the sampled inputs.
    task automatic modelStep(input bit rst, input bit lv, input int val,
                             input bit ar, input bit pa, input bit ab);
        if (rst) begin
            m_active = 0; m_paused = 0; m_periodic = 0;
            m_expire = 0; m_rem = 0; m_period = 0;
            return;
        end
        m_expire = 0;
        if (!m_active) begin
            if (lv) begin
                if (val == 0) m_expire = 1;
                else begin
                    m_active = 1; m_rem = val; m_period = val; m_periodic = ar;
                end
            end
        end else if (ab) begin
            m_active = 0; m_paused = 0; m_rem = 0;
        end else if (m_paused) begin
            if (!pa) m_paused = 0;
        end else if (pa) begin
            m_paused = 1;
        end else if (m_rem > 1) begin
            m_rem = m_rem - 1;
        end else begin
            m_expire = 1;
            if (m_periodic) m_rem = m_period;
            else begin
                m_active = 0; m_rem = 0;
            end
        end
    endtask

    // Compare process: step the model on each edge, then check every output just after it.
    always begin
        @(posedge clk);
        modelStep(reset, load_valid_i, int'(load_val_i), auto_reload_i, pause_i, abort_i);
        model_on = 1;
        #1;
        checkOutput("model count_o", int'(count_o), m_rem);
        checkOutput("model busy_o", int'(busy_o), int'(m_active));
        checkOutput("model expire_o", int'(expire_o), int'(m_expire));
        checkOutput("model load_ready_o", int'(load_ready_o), int'(!reset && !m_active));
    end

    initial begin
        int exp1[5]   = '{4, 3, 2, 1, 0};
        int seq3[3]   = '{2, 1, 3};
        int exp4[7]   = '{3, 3, 3, 3, 2, 1, 0};
        bit pause4[7] = '{0, 1, 1, 0, 0, 0, 0};
        int expires;

        // Test 1: reset, then one-shot load of 5.
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("reset count", int'(count_o), 0);
        checkOutput("reset busy", int'(busy_o), 0);
        checkOutput("reset expire", int'(expire_o), 0);
        checkOutput("reset ready", int'(load_ready_o), 0);
        idleCycle();
        checkOutput("ready after reset", int'(load_ready_o), 1);
        applyStimulus(0, 1, 5, 0, 0, 0);
        checkOutput("t1 load count", int'(count_o), 5);
        checkOutput("t1 load busy", int'(busy_o), 1);
        checkOutput("t1 load ready", int'(load_ready_o), 0);
        for (int i = 0; i < 5; i++) begin
            idleCycle();
            checkOutput("t1 count", int'(count_o), exp1[i]);
            checkOutput("t1 expire", int'(expire_o), (i == 4) ? 1 : 0);
            checkOutput("t1 ready", int'(load_ready_o), (i == 4) ? 1 : 0);
        end

        // Test 2: zero-length load, then back-to-back load of 15 running to zero without wrap.
        idleCycle();
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("t2 zero expire", int'(expire_o), 1);
        checkOutput("t2 zero busy", int'(busy_o), 0);
        checkOutput("t2 zero count", int'(count_o), 0);
        applyStimulus(0, 1, 15, 0, 0, 0);
        checkOutput("t2 load15 count", int'(count_o), 15);
        checkOutput("t2 load15 expire", int'(expire_o), 0);
        expires = 0;
        for (int i = 1; i <= 15; i++) begin
            idleCycle();
            checkOutput("t2 count", int'(count_o), 15 - i);
            expires += int'(expire_o);
        end
        checkOutput("t2 expire at end", int'(expire_o), 1);
        idleCycle();
        checkOutput("t2 no wrap", int'(count_o), 0);
        checkOutput("t2 single expire", expires + int'(expire_o), 1);

        // Test 3: auto-reload 3 for four periods, then abort at count 2.
        applyStimulus(0, 1, 3, 1, 0, 0);
        checkOutput("t3 load count", int'(count_o), 3);
        expires = 0;
        for (int s = 1; s <= 12; s++) begin
            idleCycle();
            checkOutput("t3 count", int'(count_o), seq3[(s - 1) % 3]);
            checkOutput("t3 expire", int'(expire_o), (s % 3 == 0) ? 1 : 0);
            expires += int'(expire_o);
        end
        checkOutput("t3 period count", expires, 4);
        idleCycle();
        checkOutput("t3 pre-abort count", int'(count_o), 2);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("t3 abort count", int'(count_o), 0);
        checkOutput("t3 abort busy", int'(busy_o), 0);
        checkOutput("t3 abort expire", int'(expire_o), 0);

        // Test 4: load 4 with a two-cycle pause once count reaches 3; expiry slips to 7.
        applyStimulus(0, 1, 4, 0, 0, 0);
        for (int s = 0; s < 7; s++) begin
            applyStimulus(0, 0, 0, 0, pause4[s], 0);
            checkOutput("t4 count", int'(count_o), exp4[s]);
            checkOutput("t4 expire", int'(expire_o), (s == 6) ? 1 : 0);
        end

        // Test 5: load ignored while busy; reset mid-run.
        applyStimulus(0, 1, 6, 0, 0, 0);
        applyStimulus(0, 1, 9, 0, 0, 0);
        checkOutput("t5 load ignored", int'(count_o), 5);
        idleCycle();
        idleCycle();
        idleCycle();
        checkOutput("t5 pre-reset count", int'(count_o), 2);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("t5 reset count", int'(count_o), 0);
        checkOutput("t5 reset busy", int'(busy_o), 0);
        checkOutput("t5 reset expire", int'(expire_o), 0);
        checkOutput("t5 reset ready", int'(load_ready_o), 0);
        idleCycle();
        checkOutput("t5 ready back", int'(load_ready_o), 1);

        // Test 6: abort beats pause in RUN; abort is ignored in IDLE so the load wins.
        applyStimulus(0, 1, 5, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("t6 abort+pause busy", int'(busy_o), 0);
        checkOutput("t6 abort+pause count", int'(count_o), 0);
        applyStimulus(0, 1, 7, 0, 0, 1);
        checkOutput("t6 abort+load count", int'(count_o), 7);
        checkOutput("t6 abort+load busy", int'(busy_o), 1);
        for (int i = 0; i < 8; i++) idleCycle();

        // Randomized traffic, checked only by the compare process.
        for (int i = 0; i < 3000; i++) begin
            bit r, lv, ar, pa, ab;
            int v;
            r  = ($urandom_range(0, 299) == 0);
            lv = ($urandom_range(0, 1) == 1);
            v  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
            ar = ($urandom_range(0, 2) == 0);
            pa = ($urandom_range(0, 9) == 0);
            ab = ($urandom_range(0, 29) == 0);
            applyStimulus(r, lv, v, ar, pa, ab);
        end
        idleCycle();

        checkOutput("model ran", int'(model_on), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_load_down_timer

// File: doc/load_down_timer.md
# load_down_timer

- Loadable down-counting timer; the consumer-side counterpart of the team's loadable up-counter.
- Accepts a start value over a valid/ready load handshake and decrements once per active cycle.
- Signals expiry with a one-cycle pulse; optionally auto-reloads to run as a periodic tick source.
- Sits beside the up-counter in the counter/timer exercise set and drives timeouts and periodic strobes.

## Interface
- WIDTH, default 4, bit width of load value and count.
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- load_valid_i  input  1  load request.
- load_val_i  input  WIDTH  start value; sampled when load_valid_i && load_ready_o.
- auto_reload_i  input  1  sampled with the load; 1 = periodic mode.
- pause_i  input  1  freezes the count while high.
- abort_i  input  1  cancels a running timer.
- load_ready_o  output  1  high only in IDLE and not in reset.
- count_o  output  WIDTH  current remaining count.
- busy_o  output  1  high in RUN or HOLD.
- expire_o  output  1  registered one-cycle expiry pulse.

## Operation
- Reset values: state IDLE, count_o 0, busy_o 0, expire_o 0, stored reload value 0, stored auto-reload flag 0. load_ready_o is 0 while reset is high and 1 afterwards.
- Reset mid-operation: reset has top priority. The cycle after the reset edge shows the reset values, with no expire pulse.
- States:
  - IDLE: load_ready_o=1.
    - Accepted load with N≠0: count←N, store N and auto_reload_i, go to RUN.
    - Accepted load with N=0: count stays 0, expire_o←1, remain IDLE (zero-length timer).
    - abort_i and pause_i are ignored.
  - RUN:
    - abort_i=1: go to IDLE, count←0, no expire.
    - Else pause_i=1: count holds, go to HOLD.
    - Else count>1: count←count−1.
    - Else count==1, auto-reload off: count←0, expire_o←1, go to IDLE.
    - Else count==1, auto-reload on: count←stored N, expire_o←1, stay in RUN.
  - HOLD:
    - abort_i=1: go to IDLE, count←0.
    - pause_i=0: go to RUN, with no decrement on that edge.
    - Otherwise count holds.
- Priority: reset > abort > pause > decrement/expiry.
- Load attempts while busy are ignored; no queuing.
- Arithmetic: unsigned, no wrap. Count never passes below 0 and never exceeds 2^WIDTH−1.

## Timing
- Load accepted on edge k: count_o=N and busy_o=1 from edge k.
- Without pauses, count_o reads N−j after edge k+j.
- One-shot mode: after edge k+N, count_o=0, expire_o=1, busy_o=0 and load_ready_o=1, all in the same cycle. A new load is accepted in that cycle, giving back-to-back runs with zero dead cycles.
- Auto-reload mode: expire_o pulses once every N cycles, and count_o cycles N…1 with no 0 ever visible.
- Each HOLD entry adds (cycles pause_i high) + 1 cycles to the expiry time.
- Zero load on edge k: expire_o=1 in the cycle after edge k; busy_o never rises.
- expire_o is high for exactly one cycle per expiry.
- All outputs are registered except load_ready_o, which decodes state and reset.

## Structure
- Shared package load_timer_pkg:
  - typedef enum logic [1:0] timer_state_t {IDLE=2'b00, RUN=2'b01, HOLD=2'b10}.
  - Localparam TIMER_WIDTH_DEFAULT=4.
- Single module: the FSM, count register, reload register and expire flop are inline. No sub-module is natural.

## Test plan (WIDTH=4)
1. Reset 2 cycles, then load 5, one-shot → count 5,4,3,2,1,0 on successive edges; expire_o high only in the cycle with count 0; load_ready_o 0 for 5 cycles, then 1.
2. Load 0 → next cycle expire_o=1, busy_o=0, count_o=0. Immediately load 15 → 15 decrement cycles, count stays at 0 at the end, no wrap.
3. Auto-reload load 3 → count 3,2,1,3,2,1,…; expire_o every 3rd cycle for 4 periods. abort_i while count=2 → next cycle count 0, busy 0, no expire.
4. Load 4, pause_i high for 2 cycles after count reaches 3 → count holds at 3 for 3 cycles; expire at 7 cycles after the load instead of 4.
5. While running from 6, assert load_valid_i with value 9 → ignored, count unaffected. Assert reset at count 2 → next cycle all outputs at reset values, no expire.
6. Simultaneous abort_i and pause_i in RUN → IDLE. Simultaneous abort_i and load_valid_i in IDLE → load accepted.
